gray_counter: RTL and testbench



---
 rtl/gray_counter.sv | 71 +++++++
 tb/tb_gray_counter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with binary/Gray parallel load and a wrap pulse.
// Gray, binary and wrap are all flopped, so gray_out changes one bit per count step.
module gray_counter #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic             load_is_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] InitBin  = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] InitGray = InitBin ^ (InitBin >> 1);
   localparam logic [WIDTH-1:0] One      = {{(WIDTH - 1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MaxCount = {WIDTH{1'b1}};

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;

   function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_is_gray ? gray_to_bin(load_val) : load_val;
      end else if (en) begin
         if (up_dn) begin
            bin_d  = bin_q + One;
            wrap_d = (bin_q == MaxCount);
         end else begin
            bin_d  = bin_q - One;
            wrap_d = (bin_q == '0);
         end
      end
      // Gray is encoded ahead of the flop so the output pin is a clean register.
      gray_d = bin_d ^ (bin_d >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= InitBin;
         gray_q <= InitGray;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a 3-bit INIT=5 instance for directed cases and an
// 8-bit instance for a randomised run against a behavioural model.
module tb_gray_counter;

   typedef struct {
      logic [7:0] bin;
      logic [7:0] gray;
      logic       wrap;
   } exp_t;

   logic clk;
   logic rst_n;

   logic       a_en, a_up, a_ld, a_lig;
   logic [2:0] a_val, a_bin, a_gray;
   logic       a_wrap;

   logic       b_en, b_up, b_ld, b_lig;
   logic [7:0] b_val, b_bin, b_gray;
   logic       b_wrap;

   exp_t sb_a[$];
   exp_t sb_b[$];
   logic [7:0] ma;
   logic [7:0] mb;

   int n_checks;
   int n_fail;

   gray_counter #(.WIDTH(3), .INIT(5)) u_dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (a_en),
      .up_dn        (a_up),
      .load         (a_ld),
      .load_is_gray (a_lig),
      .load_val     (a_val),
      .bin_out      (a_bin),
      .gray_out     (a_gray),
      .wrap         (a_wrap)
   );

   gray_counter #(.WIDTH(8), .INIT(0)) u_dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (b_en),
      .up_dn        (b_up),
      .load         (b_ld),
      .load_is_gray (b_lig),
      .load_val     (b_val),
      .bin_out      (b_bin),
      .gray_out     (b_gray),
      .wrap         (b_wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model_next(input int w, input logic [7:0] cur, input logic en,
                                       input logic up, input logic ld, input logic lig,
                                       input logic [7:0] val);
      exp_t       e;
      logic [7:0] mask;
      logic [7:0] g;
      logic [7:0] b;
      mask = 8'((1 << w) - 1);
      e.wrap = 1'b0;
      if (ld) begin
         g = val & mask;
         b = g;
         if (lig) begin
            for (int k = 1; k < 8; k++) b = b ^ (g >> k);
         end
         e.bin = b & mask;
      end else if (en) begin
         if (up) begin
            e.bin  = (cur + 8'd1) & mask;
            e.wrap = (cur == mask);
         end else begin
            e.bin  = (cur - 8'd1) & mask;
            e.wrap = (cur == 8'd0);
         end
      end else begin
         e.bin = cur;
      end
      e.gray = e.bin ^ (e.bin >> 1);
      return e;
   endfunction

   // Drive one cycle on instance A, push its expected result, return 1 ns after the edge.
   task automatic drive_a(input logic en, input logic up, input logic ld, input logic lig,
                          input logic [2:0] val);
      exp_t e;
      a_en = en; a_up = up; a_ld = ld; a_lig = lig; a_val = val;
      e = model_next(3, ma, en, up, ld, lig, {5'd0, val});
      ma = e.bin;
      sb_a.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drive_b(input logic en, input logic up, input logic ld, input logic lig,
                          input logic [7:0] val);
      exp_t e;
      b_en = en; b_up = up; b_ld = ld; b_lig = lig; b_val = val;
      e = model_next(8, mb, en, up, ld, lig, val);
      mb = e.bin;
      sb_b.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
         e = sb_a.pop_front();
         n_checks++;
         if (a_bin !== e.bin[2:0] || a_wrap !== e.wrap) begin
            n_fail++;
            $display("FAIL pre_reset_count step %0d: got bin=%b wrap=%b, want bin=%b wrap=%b",
                     i, a_bin, a_wrap, e.bin[2:0], e.wrap);
         end
      end
      a_en = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (a_bin !== 3'b101 || a_gray !== 3'b111 || a_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got bin=%b gray=%b wrap=%b, want 101 111 0",
                  a_bin, a_gray, a_wrap);
      end
      n_checks++;
      if (b_bin !== 8'd0 || b_gray !== 8'd0 || b_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_wide: got bin=%h gray=%h wrap=%b, want 00 00 0",
                  b_bin, b_gray, b_wrap);
      end
      ma = 8'd5;
      mb = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         drive_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
         e = sb_a.pop_front();
         n_checks++;
         if (a_bin !== 3'b101 || a_gray !== 3'b111 || a_wrap !== 1'b0 || e.bin !== 8'd5) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: got bin=%b gray=%b wrap=%b, want 101 111 0",
                     i, a_bin, a_gray, a_wrap);
         end
      end
      drive_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      e = sb_a.pop_front();
      n_checks++;
      if (a_bin !== e.bin[2:0] || a_gray !== e.gray[2:0] || a_wrap !== e.wrap) begin
         n_fail++;
         $display("FAIL first_step: got bin=%b gray=%b wrap=%b, want %b %b %b",
                  a_bin, a_gray, a_wrap, e.bin[2:0], e.gray[2:0], e.wrap);
      end
   endtask

   task automatic test_up_sweep;
      exp_t       e;
      logic [2:0] seq [9];
      logic [2:0] prev;
      seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      drive_a(1'b0, 1'b1, 1'b1, 1'b0, 3'd7);
      void'(sb_a.pop_front());
      prev = a_gray;
      for (int i = 0; i < 9; i++) begin
         drive_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
         e = sb_a.pop_front();
         n_checks++;
         if (a_gray !== seq[i] || a_wrap !== (i == 0 || i == 8) || a_gray !== e.gray[2:0]) begin
            n_fail++;
            $display("FAIL up_sweep step %0d: got gray=%b wrap=%b, want gray=%b wrap=%b",
                     i, a_gray, a_wrap, seq[i], (i == 0 || i == 8));
         end
         n_checks++;
         if ($countones(a_gray ^ prev) != 1) begin
            n_fail++;
            $display("FAIL up_sweep_onebit step %0d: got %b -> %b, want one bit change",
                     i, prev, a_gray);
         end
         prev = a_gray;
      end
   endtask

   task automatic test_down_wrap;
      exp_t e;
      logic [2:0] want_bin [3];
      logic       want_wrap [3];
      want_bin  = '{3'd0, 3'd7, 3'd0};
      want_wrap = '{1'b0, 1'b1, 1'b1};
      drive_a(1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
      void'(sb_a.pop_front());
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, (i == 2), 1'b0, 1'b0, 3'd0);
         e = sb_a.pop_front();
         n_checks++;
         if (a_bin !== want_bin[i] || a_wrap !== want_wrap[i] || a_gray !== e.gray[2:0]) begin
            n_fail++;
            $display("FAIL down_wrap step %0d: got bin=%b gray=%b wrap=%b, want %b %b %b",
                     i, a_bin, a_gray, a_wrap, want_bin[i], e.gray[2:0], want_wrap[i]);
         end
      end
   endtask

   task automatic test_load_priority;
      exp_t e;
      drive_a(1'b0, 1'b1, 1'b1, 1'b0, 3'd7);
      void'(sb_a.pop_front());
      drive_a(1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
      e = sb_a.pop_front();
      n_checks++;
      if (a_bin !== 3'b011 || a_gray !== 3'b010 || a_wrap !== 1'b0 || e.bin !== 8'd3) begin
         n_fail++;
         $display("FAIL load_priority: got bin=%b gray=%b wrap=%b, want 011 010 0",
                  a_bin, a_gray, a_wrap);
      end
   endtask

   task automatic test_load_hold;
      exp_t e;
      drive_a(1'b0, 1'b0, 1'b1, 1'b0, 3'b110);
      e = sb_a.pop_front();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (a_bin !== 3'b110 || a_gray !== 3'b101 || a_wrap !== 1'b0 || e.bin !== 8'd6) begin
            n_fail++;
            $display("FAIL load_hold cycle %0d: got bin=%b gray=%b wrap=%b, want 110 101 0",
                     i, a_bin, a_gray, a_wrap);
         end
         if (i < 3) begin
            drive_a(1'b0, 1'b1, 1'b0, 1'b1, 3'b011);
            e = sb_a.pop_front();
         end
      end
   endtask

   task automatic test_random;
      exp_t       e;
      logic       en, up, ld, lig;
      logic [7:0] prev;
      prev = b_gray;
      for (int i = 0; i < 20000; i++) begin
         en  = 1'($urandom_range(0, 1));
         up  = 1'($urandom_range(0, 1));
         ld  = ($urandom_range(0, 7) == 0);
         lig = 1'($urandom_range(0, 1));
         // Bias toward ends of range so wraps are frequent.
         drive_b(en, up, ld, lig, ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom));
         e = sb_b.pop_front();
         n_checks++;
         if (b_bin !== e.bin || b_gray !== e.gray || b_wrap !== e.wrap) begin
            n_fail++;
            $display("FAIL random cycle %0d: got bin=%h gray=%h wrap=%b, want %h %h %b",
                     i, b_bin, b_gray, b_wrap, e.bin, e.gray, e.wrap);
         end
         n_checks++;
         if (b_gray !== (b_bin ^ (b_bin >> 1))) begin
            n_fail++;
            $display("FAIL random_gray_rel cycle %0d: got gray=%h, want %h",
                     i, b_gray, b_bin ^ (b_bin >> 1));
         end
         if (en && !ld) begin
            n_checks++;
            if ($countones(b_gray ^ prev) != 1) begin
               n_fail++;
               $display("FAIL random_onebit cycle %0d: got %h -> %h, want one bit change",
                        i, prev, b_gray);
            end
         end
         prev = b_gray;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      a_en = 1'b0; a_up = 1'b0; a_ld = 1'b0; a_lig = 1'b0; a_val = 3'd0;
      b_en = 1'b0; b_up = 1'b0; b_ld = 1'b0; b_lig = 1'b0; b_val = 8'd0;
      ma = 8'd5;
      mb = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_up_sweep();
      test_down_wrap();
      test_load_priority();
      test_load_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
